// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed active-low 7-segment bus, debounces
// each scan slot, decodes it to hex and assembles a NUM_DIGITS-digit word.
// Latency: pins stable from edge k -> capture/value/frame_valid at edge k+2+STABLE_CYCLES.
// Backpressure: none; the display bus free-runs and frame_valid is a one-cycle pulse.
//
// Optional feature macro: SEG_SCAN_CAPTURE_ERRCNT_EN adds o_err_count, a
// saturating 8-bit count of error events cleared by i_err_clr.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_seg[6:0]     {a,b,c,d,e,f,g}, active-low segments, asynchronous to i_clk
//   i_an[N-1:0]    anode enables, active-low; bit i low selects digit i
//   i_err_clr      synchronous pulse clearing o_err / o_err_code (/ o_err_count)
//   o_value        last complete frame; digit i at [4i+3:4i]
//   o_frame_valid  one-cycle pulse, o_value updated on the same edge
//   o_err          sticky error flag
//   o_err_code     00 none, 01 invalid segment pattern, 10 multiple anodes
//   o_err_count    (macro only) saturating error event count

module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [6:0]              i_seg,
    input  logic [NUM_DIGITS-1:0]   i_an,
    input  logic                    i_err_clr,
    output logic [4*NUM_DIGITS-1:0] o_value,
    output logic                    o_frame_valid,
    output logic                    o_err,
    output logic [1:0]              o_err_code
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0]              o_err_count
`endif
);

    localparam logic [7:0] C_STABLE    = 8'(STABLE_CYCLES);
    localparam logic [7:0] C_STABLE_M1 = 8'(STABLE_CYCLES - 1);
    localparam logic [1:0] C_ERR_NONE  = 2'b00;
    localparam logic [1:0] C_ERR_PAT   = 2'b01;
    localparam logic [1:0] C_ERR_MULTI = 2'b10;
    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

    // Two-flop synchronizers, reset to blank / anodes off
    logic [6:0]              r_seg_s1, r_seg_s2;
    logic [NUM_DIGITS-1:0]   r_an_s1,  r_an_s2;

    // Stability tracking
    logic [6:0]              r_held_seg;
    logic [NUM_DIGITS-1:0]   r_held_an;
    logic [7:0]              r_cnt;

    // Frame assembly and outputs
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic                    r_frame_valid;
    logic                    r_err;
    logic [1:0]              r_err_code;

    logic                    w_change;
    logic                    w_capture;
    logic [NUM_DIGITS-1:0]   w_an_act;
    logic [NUM_DIGITS-1:0]   w_an_rest;
    logic                    w_one_hot;
    logic                    w_multi;
    logic                    w_dec_vld;
    logic [3:0]              w_dec_val;
    logic                    w_seg_blank;
    logic                    w_wr;
    logic                    w_bad_pat;
    logic                    w_bad_an;
    logic                    w_err_evt;
    logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
    logic [NUM_DIGITS-1:0]   w_seen_nxt;
    logic                    w_frame_done;

    // Segment pattern (a is the MSB) back to its hex nibble
    always_comb begin
        w_dec_vld = 1'b1;
        w_dec_val = 4'h0;
        case (r_held_seg)
            7'b0000001: w_dec_val = 4'h0;
            7'b1001111: w_dec_val = 4'h1;
            7'b0010010: w_dec_val = 4'h2;
            7'b0000110: w_dec_val = 4'h3;
            7'b1001100: w_dec_val = 4'h4;
            7'b0100100: w_dec_val = 4'h5;
            7'b0100000: w_dec_val = 4'h6;
            7'b0001111: w_dec_val = 4'h7;
            7'b0000000: w_dec_val = 4'h8;
            7'b0001100: w_dec_val = 4'h9;
            7'b0001000: w_dec_val = 4'hA;
            7'b1100000: w_dec_val = 4'hB;
            7'b0110001: w_dec_val = 4'hC;
            7'b1000010: w_dec_val = 4'hD;
            7'b0110000: w_dec_val = 4'hE;
            7'b0111000: w_dec_val = 4'hF;
            default:    w_dec_vld = 1'b0;
        endcase
    end

    always_comb begin
        w_change  = (r_seg_s2 != r_held_seg) || (r_an_s2 != r_held_an);
        // Fires once per stable interval: only the STABLE-1 -> STABLE step
        w_capture = !w_change && (r_cnt == C_STABLE_M1);

        w_an_act  = ~r_held_an;
        // Clearing the lowest set bit leaves zero only for a one-hot mask
        w_an_rest = w_an_act & (w_an_act - NUM_DIGITS'(1));
        w_one_hot = (w_an_act != '0) && (w_an_rest == '0);
        w_multi   = (w_an_rest != '0);

        w_seg_blank = (r_held_seg == C_SEG_BLANK);
        w_wr        = w_capture && w_one_hot && w_dec_vld;
        w_bad_pat   = w_capture && w_one_hot && !w_dec_vld && !w_seg_blank;
        w_bad_an    = w_capture && w_multi;
        w_err_evt   = w_bad_pat || w_bad_an;

        w_shadow_nxt = r_shadow;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_wr && w_an_act[i]) begin
                w_shadow_nxt[4*i +: 4] = w_dec_val;
            end
        end
        w_seen_nxt   = w_wr ? (r_seen | w_an_act) : r_seen;
        w_frame_done = w_wr && (&w_seen_nxt);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg_s1      <= '1;
            r_seg_s2      <= '1;
            r_an_s1       <= '1;
            r_an_s2       <= '1;
            r_held_seg    <= '1;
            r_held_an     <= '1;
            r_cnt         <= '0;
            r_shadow      <= '0;
            r_seen        <= '0;
            r_value       <= '0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= C_ERR_NONE;
        end else begin
            r_seg_s1 <= i_seg;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= i_an;
            r_an_s2  <= r_an_s1;

            if (w_change) begin
                r_held_seg <= r_seg_s2;
                r_held_an  <= r_an_s2;
                r_cnt      <= '0;
            end else if (r_cnt != C_STABLE) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_wr) begin
                r_shadow <= w_shadow_nxt;
            end
            if (w_frame_done) begin
                r_seen  <= '0;
                r_value <= w_shadow_nxt;
            end else begin
                r_seen  <= w_seen_nxt;
            end
            r_frame_valid <= w_frame_done;

            // A new error outranks a simultaneous clear
            if (w_err_evt) begin
                r_err      <= 1'b1;
                r_err_code <= w_bad_an ? C_ERR_MULTI : C_ERR_PAT;
            end else if (i_err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= C_ERR_NONE;
            end
        end
    end

`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_count <= '0;
        end else if (i_err_clr) begin
            r_err_count <= w_err_evt ? 8'd1 : 8'd0;
        end else if (w_err_evt && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign o_err_count = r_err_count;
`endif

    assign o_value       = r_value;
    assign o_frame_valid = r_frame_valid;
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed test of the seven-segment scan capture block.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked there too.
// Backpressure: none.

module tb_seg_scan_capture;

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0001100, PA = 7'b0001000, PB = 7'b1100000;
    localparam logic [6:0] PC = 7'b0110001, PD = 7'b1000010, PE = 7'b0110000;
    localparam logic [6:0] PF = 7'b0111000, PBLANK = 7'b1111111, PBAD = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic        err_clr = 1'b0;
    logic [15:0] value;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_code;
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fv_count = 0;
    int fv_cyc = 0;
    int fv_b2b = 0;
    bit fv_prev = 1'b0;
    int c0 = 0;
    int fv_base = 0;

    seg_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_seg         (seg),
        .i_an          (an),
        .i_err_clr     (err_clr),
        .o_value       (value),
        .o_frame_valid (frame_valid),
        .o_err         (err),
        .o_err_code    (err_code)
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
        ,
        .o_err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every frame_valid pulse and the edge it belongs to
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_count++;
            fv_cyc = cyc;
            if (fv_prev) fv_b2b++;
        end
        fv_prev = frame_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; holds pins for n cycles and returns at posedge+1
    task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
        seg = s;
        an  = a;
        c0  = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        // ---------------- reset with garbage on the pins ----------------
        @(posedge clk);
        #1;
        repeat (5) begin
            seg = 7'($urandom);
            an  = 4'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_value", value, 16'h0000);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_code", err_code, 2'b00);
        seg   = PBLANK;
        an    = 4'hF;
        rst_n = 1'b1;
        drive(PBLANK, 4'hF, 50);
        chk("idle_value", value, 16'h0000);
        chk("idle_fv_count", fv_count, 0);
        chk("idle_err", err, 1'b0);
        chk("idle_code", err_code, 2'b00);
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
        chk("idle_cnt", err_count, 8'd0);
`endif

        // ---------------- full frame 4321 twice ----------------
        drive(P1, 4'b1110, 8);
        drive(P2, 4'b1101, 8);
        drive(P3, 4'b1011, 8);
        drive(P4, 4'b0111, 8);
        chk("frame1_count", fv_count, 1);
        chk("frame1_latency", fv_cyc, c0 + 7);
        chk("frame1_value", value, 16'h4321);
        chk("frame1_err", err, 1'b0);
        drive(P1, 4'b1110, 8);
        drive(P2, 4'b1101, 8);
        drive(P3, 4'b1011, 8);
        drive(P4, 4'b0111, 8);
        chk("frame2_count", fv_count, 2);
        chk("frame2_value", value, 16'h4321);

        // ---------------- debounce: 3-cycle glitch of an 8 on digit 0 ----------------
        drive(P5, 4'b1110, 8);
        drive(P8, 4'b1110, 3);
        chk("glitch_value", value, 16'h4321);
        drive(P6, 4'b1101, 8);
        drive(P7, 4'b1011, 8);
        drive(P9, 4'b0111, 8);
        chk("glitch_count", fv_count, 3);
        chk("glitch_frame", value, 16'h9765);
        drive(PBLANK, 4'hF, 8);

        // ---------------- invalid segment pattern ----------------
        drive(PBAD, 4'b1101, 8);
        chk("badpat_err", err, 1'b1);
        chk("badpat_code", err_code, 2'b01);
        chk("badpat_nofv", fv_count, 3);
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
        chk("badpat_cnt", err_count, 8'd1);
`endif
        drive(PBLANK, 4'hF, 4);
        pulse_clr();
        chk("clr_err", err, 1'b0);
        chk("clr_code", err_code, 2'b00);
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
        chk("clr_cnt", err_count, 8'd0);
`endif

        // ---------------- multiple anodes: error, no data write ----------------
        drive(P0, 4'b1100, 8);
        chk("multi_err", err, 1'b1);
        chk("multi_code", err_code, 2'b10);
        chk("multi_value", value, 16'h9765);
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
        chk("multi_cnt", err_count, 8'd1);
`endif
        // Digits 0/1 must not count as seen, so 2 and 3 alone cannot finish a frame
        drive(PA, 4'b1011, 8);
        drive(PB, 4'b0111, 8);
        chk("multi_noframe", fv_count, 3);
        drive(PC, 4'b1110, 8);
        drive(PD, 4'b1101, 8);
        chk("multi_frame_count", fv_count, 4);
        chk("multi_frame_value", value, 16'hBADC);
        drive(PBLANK, 4'hF, 8);

        // ---------------- err_clr on the same edge as a new error ----------------
        seg = PBAD;
        an  = 4'b1101;
        repeat (6) @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_race_err", err, 1'b1);
        chk("clr_race_code", err_code, 2'b01);
`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
        chk("clr_race_cnt", err_count, 8'd1);
`endif
        drive(PBAD, 4'b1101, 2);
        drive(P0, 4'b0011, 8);
        chk("overwrite_code", err_code, 2'b10);
        drive(PBLANK, 4'hF, 4);
        pulse_clr();

`ifdef SEG_SCAN_CAPTURE_ERRCNT_EN
        // ---------------- 300 errors saturate the counter ----------------
        for (int i = 0; i < 300; i++) begin
            drive(P0, (i % 2 == 0) ? 4'b1010 : 4'b1100, 7);
        end
        chk("sat_cnt", err_count, 8'd255);
        drive(PBLANK, 4'hF, 4);
        pulse_clr();
        chk("sat_clr_cnt", err_count, 8'd0);
`endif
        chk("pre_rst_err", err, 1'b0);

        // ---------------- reset mid-frame discards partial state ----------------
        drive(P1, 4'b1110, 8);
        drive(P2, 4'b1101, 8);
        rst_n = 1'b0;
        drive(PBLANK, 4'hF, 3);
        chk("midrst_value", value, 16'h0000);
        chk("midrst_err", err, 1'b0);
        rst_n = 1'b1;
        drive(PBLANK, 4'hF, 4);
        fv_base = fv_count;
        drive(PC, 4'b0111, 8);
        drive(PD, 4'b1011, 8);
        chk("midrst_nostale", fv_count, fv_base);
        drive(PE, 4'b1101, 8);
        drive(PF, 4'b1110, 8);
        chk("midrst_count", fv_count, fv_base + 1);
        chk("midrst_frame", value, 16'hCDEF);
        chk("fv_never_b2b", fv_b2b, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the hex-to-seven-segment driver.
- Samples a multiplexed, active-low seven-segment bus (segments a..g plus per-digit anode enables), debounces each scan slot, and decodes each segment pattern back to its 4-bit hex value.
- Assembles a NUM_DIGITS-digit word and flags malformed patterns.
- Used as an on-chip display monitor / self-check path and as the bench-side checker for display outputs.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), range 1..8.
- STABLE_CYCLES, 4, synchronized cycles a {an,seg} pattern must hold before capture, range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, reset asynchronous and active-low.
- seg  input  7  {a,b,c,d,e,f,g}, active-low segments, asynchronous to clk.
- an  input  NUM_DIGITS  anode enables, active-low; bit i low selects digit i.
- err_clr  input  1  synchronous pulse that clears err and err_code.
- value  output  4*NUM_DIGITS  last complete frame; digit i occupies [4i+3:4i].
- frame_valid  output  1  one-cycle pulse; value updated on the same edge.
- err  output  1  sticky error flag.
- err_code  output  2  00 none, 01 invalid segment pattern, 10 multiple anodes active.

Behaviour:
- Reset (async, rst_n=0):
  - value=0, frame_valid=0, err=0, err_code=00.
  - Digit-seen mask=0, shadow=0, stability counter=0.
  - Synchronizer and held registers all-ones (blank, anodes off).
- Synchronization: seg and an each pass through a 2-flop synchronizer. All logic below uses the second stage, called s.
- Stability tracking:
  - If s != held: held<=s, cnt<=0.
  - Else cnt increments, saturating at STABLE_CYCLES.
  - The capture event fires on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. This is exactly one event per stable interval.
- Capture classification, by held.an:
  - All ones: blanked slot; no action.
  - Exactly one bit i low, decoded by the held.seg table below:
    - If the pattern matches, write shadow[4i+3:4i] and set seen[i].
    - If held.seg=1111111, treat as a blank digit; no action, no error.
    - Any other pattern: err<=1, err_code<=01; shadow and seen[i] unchanged.
  - Two or more bits low: err<=1, err_code<=10; no data update.
- Decode table, seg pattern to value:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0001100=9, 0001000=A, 1100000=b
  - 0110001=C, 1000010=d, 0110000=E, 0111000=F
- Frame completion:
  - Checked on the same capture edge. If (seen | new bit) is all ones: value<=shadow including the new nibble, frame_valid<=1, seen<=0.
  - frame_valid is otherwise 0; it is never high two consecutive cycles.
  - Re-capturing an already-seen digit before the frame completes overwrites its nibble; the latest value wins.
- Latency: pins stable from edge k gives capture, value and frame_valid at edge k+2+STABLE_CYCLES. With defaults this is k+6.
- Errors:
  - err is sticky until err_clr.
  - A new error on the same edge as err_clr wins (err stays 1, new code).
  - A later error overwrites err_code.
- Glitches: a pattern shorter than STABLE_CYCLES+1 synchronized samples resets cnt and is never captured.
- Reset mid-frame: discards partial shadow and seen; the next frame starts clean.

Optional Feature:
- Macro: SEG_SCAN_CAPTURE_ERRCNT_EN.
- When defined:
  - Adds output err_count (8 bits, reset 0).
  - err_count increments on every error event and saturates at 255.
  - err_clr zeroes it; an error on the same edge as err_clr gives err_count=1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold rst_n=0 with random seg/an, then release with an=1111 → value=0000, frame_valid, err and err_code stay 0 for 50 cycles.
- Full frame: scan digits 0..3 with patterns for 1,2,3,4 (0010010/1001111/0000110/1001100 mapped 2,1,3,4 accordingly), 8 cycles per slot, then repeat → single frame_valid pulse, value=16'h4321, err=0. Verify the pulse lands at edge k+6 relative to the stable last slot.
- Debounce: apply a 3-cycle pattern 0000000 on an=1110 between valid slots → no capture, seen unchanged, value unaffected.
- Invalid pattern: seg=1010101 on an=1101, held 8 cycles → err=1, err_code=01, no frame. Assert err_clr → err=0, err_code=00.
- Multi-anode: an=1100 with seg=0000001 → err_code=10, no nibble write. With the macro enabled, err_count=1.
- Boundary: err_clr on the same edge as a new error → err stays 1. Force 300 errors with the macro enabled → err_count saturates at 255. Assert rst_n low mid-frame after 2 digits → the next full scan of F,E,d,C yields value=16'hCdEF with no stale nibbles.
